// File: rtl/id_regfile_bypass.sv
`default_nettype none
// ============================================================================
// Module   : id_regfile_bypass
// Purpose  : ID-stage GPR file with EXE>MEM>WB forwarding and load-use stall.
// Revision : 1.0
// ============================================================================
module id_regfile_bypass #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wb_to_id_valid,
  input  logic              wb_reg_we,
  input  logic [ADDR_W-1:0] wb_reg_waddr,
  input  logic [DATA_W-1:0] wb_final_result,
  input  logic              exe_valid,
  input  logic              exe_reg_we,
  input  logic [ADDR_W-1:0] exe_reg_waddr,
  input  logic              exe_is_load,
  input  logic [DATA_W-1:0] exe_result,
  input  logic              mem_valid,
  input  logic              mem_reg_we,
  input  logic [ADDR_W-1:0] mem_reg_waddr,
  input  logic [DATA_W-1:0] mem_final_result,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic              rs_used,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              rt_used,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              id_stall
);

  localparam logic [ADDR_W-1:0] C_R0 = '0;

  logic [DATA_W-1:0] r_rf [NREG];

  logic w_wb_wr;
  logic w_exe_wr;
  logic w_mem_wr;
  logic w_exe_ld;

  // r0 targets are excluded here so they neither commit nor forward
  assign w_wb_wr  = wb_to_id_valid && wb_reg_we  && (wb_reg_waddr  != C_R0);
  assign w_exe_wr = exe_valid      && exe_reg_we && (exe_reg_waddr != C_R0);
  assign w_mem_wr = mem_valid      && mem_reg_we && (mem_reg_waddr != C_R0);
  assign w_exe_ld = w_exe_wr && exe_is_load;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_wb_wr) begin
      r_rf[wb_reg_waddr] <= wb_final_result;
    end
  end

  function automatic logic [DATA_W-1:0] fwd_read(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if (addr == C_R0) begin
      val = '0;
    end else if (w_exe_wr && (exe_reg_waddr == addr)) begin
      val = exe_result;
    end else if (w_mem_wr && (mem_reg_waddr == addr)) begin
      val = mem_final_result;
    end else if (w_wb_wr && (wb_reg_waddr == addr)) begin
      val = wb_final_result;
    end else begin
      val = r_rf[addr];
    end
    return val;
  endfunction

  always_comb begin
    rs_data = fwd_read(rs_addr);
    rt_data = fwd_read(rt_addr);
  end

  // A load in EXE has no data yet; a consumer must wait until it reaches MEM
  always_comb begin
    id_stall = id_valid && w_exe_ld &&
               ((rs_used && (rs_addr == exe_reg_waddr)) ||
                (rt_used && (rt_addr == exe_reg_waddr)));
  end

endmodule
`default_nettype wire

// File: tb/tb_id_regfile_bypass.sv
`default_nettype none
// Directed bench for id_regfile_bypass: reference model of the GPR file plus literal checks.
`timescale 1ns/100ps
module tb_id_regfile_bypass;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_to_id_valid, wb_reg_we;
  logic [4:0]  wb_reg_waddr;
  logic [31:0] wb_final_result;
  logic        exe_valid, exe_reg_we, exe_is_load;
  logic [4:0]  exe_reg_waddr;
  logic [31:0] exe_result;
  logic        mem_valid, mem_reg_we;
  logic [4:0]  mem_reg_waddr;
  logic [31:0] mem_final_result;
  logic        id_valid, rs_used, rt_used;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic        id_stall;

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;
  logic [31:0] mdl [32];

  id_regfile_bypass #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
    .clk(clk), .resetn(resetn),
    .wb_to_id_valid(wb_to_id_valid), .wb_reg_we(wb_reg_we),
    .wb_reg_waddr(wb_reg_waddr), .wb_final_result(wb_final_result),
    .exe_valid(exe_valid), .exe_reg_we(exe_reg_we), .exe_reg_waddr(exe_reg_waddr),
    .exe_is_load(exe_is_load), .exe_result(exe_result),
    .mem_valid(mem_valid), .mem_reg_we(mem_reg_we), .mem_reg_waddr(mem_reg_waddr),
    .mem_final_result(mem_final_result),
    .id_valid(id_valid), .rs_addr(rs_addr), .rs_used(rs_used),
    .rt_addr(rt_addr), .rt_used(rt_used),
    .rs_data(rs_data), .rt_data(rt_data), .id_stall(id_stall)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural array plus the forwarding/stall rules
  function automatic logic [31:0] exp_read(input int a);
    if (a == 0) return 32'h0;
    if (exe_valid && exe_reg_we && int'(exe_reg_waddr) == a) return exe_result;
    if (mem_valid && mem_reg_we && int'(mem_reg_waddr) == a) return mem_final_result;
    if (wb_to_id_valid && wb_reg_we && int'(wb_reg_waddr) == a) return wb_final_result;
    return mdl[a];
  endfunction

  function automatic logic exp_stall();
    if (!(id_valid && exe_valid && exe_reg_we && exe_is_load && exe_reg_waddr != 0)) return 1'b0;
    return (rs_used && rs_addr == exe_reg_waddr) || (rt_used && rt_addr == exe_reg_waddr);
  endfunction

  always @(posedge clk) begin
    if (resetn && wb_to_id_valid && wb_reg_we && wb_reg_waddr != 0)
      mdl[wb_reg_waddr] = wb_final_result;
  end

  always @(negedge resetn) begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  end

  always @(negedge clk) begin
    if (run) begin
      chk("model_rs", rs_data, exp_read(int'(rs_addr)));
      chk("model_rt", rt_data, exp_read(int'(rt_addr)));
      chk("model_stall", {31'b0, id_stall}, {31'b0, exp_stall()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    resetn = 1'b0;
    wb_to_id_valid = 0; wb_reg_we = 0; wb_reg_waddr = 0; wb_final_result = 0;
    exe_valid = 0; exe_reg_we = 0; exe_reg_waddr = 0; exe_is_load = 0; exe_result = 0;
    mem_valid = 0; mem_reg_we = 0; mem_reg_waddr = 0; mem_final_result = 0;
    id_valid = 0; rs_addr = 0; rs_used = 0; rt_addr = 0; rt_used = 0;
    run = 1'b1;
    step(); step();
    resetn = 1'b1;
    step();

    // Reset contents: every register reads zero with all stages idle
    for (int a = 1; a < 32; a++) begin
      rs_addr = 5'(a); rt_addr = 5'(32 - a);
      #1;
      chk("reset_rs", rs_data, 32'h0);
      chk("reset_rt", rt_data, 32'h0);
    end
    chk("reset_stall", {31'b0, id_stall}, 32'h0);
    step();

    // WB write-through bypass, then array read
    wb_to_id_valid = 1; wb_reg_we = 1; wb_reg_waddr = 5; wb_final_result = 32'hDEADBEEF;
    rs_addr = 5; rt_addr = 6;
    #2 chk("wb_bypass", rs_data, 32'hDEADBEEF);
    chk("wb_other_port", rt_data, 32'h0);
    step();
    wb_to_id_valid = 0;
    #2 chk("wb_array", rs_data, 32'hDEADBEEF);
    step();

    // r0 is hard-wired to zero
    wb_to_id_valid = 1; wb_reg_waddr = 0; wb_final_result = 32'h12345678;
    rs_addr = 0; rt_addr = 0;
    #2 chk("r0_wb_same", rs_data, 32'h0);
    step();
    wb_to_id_valid = 0;
    exe_valid = 1; exe_reg_we = 1; exe_reg_waddr = 0; exe_result = 32'hFFFF;
    #2 chk("r0_after", rs_data, 32'h0);
    chk("r0_exe", rt_data, 32'h0);
    step();
    exe_valid = 0;

    // Priority on r7
    wb_to_id_valid = 1; wb_reg_waddr = 7; wb_final_result = 32'h1;
    step();
    wb_final_result = 32'h2;
    mem_valid = 1; mem_reg_we = 1; mem_reg_waddr = 7; mem_final_result = 32'h3;
    exe_valid = 1; exe_reg_we = 1; exe_reg_waddr = 7; exe_result = 32'h4;
    rs_addr = 7; rt_addr = 7;
    #1 chk("prio_exe", rs_data, 32'h4);
    chk("prio_same_addr", rt_data, rs_data);
    exe_valid = 0;
    #1 chk("prio_mem", rs_data, 32'h3);
    mem_valid = 0;
    #1 chk("prio_wb", rs_data, 32'h2);
    wb_to_id_valid = 0;
    #1 chk("prio_rf", rt_data, 32'h1);
    step();

    // Load-use on r9
    id_valid = 1; rt_addr = 9; rt_used = 1; rs_addr = 1; rs_used = 1;
    exe_valid = 1; exe_reg_we = 1; exe_reg_waddr = 9; exe_is_load = 1; exe_result = 32'h77;
    #1 chk("lu_stall", {31'b0, id_stall}, 32'h1);
    rt_used = 0;
    #1 chk("lu_unused", {31'b0, id_stall}, 32'h0);
    rt_used = 1; exe_is_load = 0;
    #1 chk("lu_notload", {31'b0, id_stall}, 32'h0);
    exe_is_load = 1;
    #1 chk("lu_stall_again", {31'b0, id_stall}, 32'h1);
    step();
    exe_valid = 0; exe_is_load = 0;
    mem_valid = 1; mem_reg_we = 1; mem_reg_waddr = 9; mem_final_result = 32'hAB;
    #2 chk("lu_mem_stall", {31'b0, id_stall}, 32'h0);
    chk("lu_mem_data", rt_data, 32'hAB);
    step();
    mem_valid = 0; id_valid = 0; rs_used = 0; rt_used = 0;

    // Asynchronous reset in the middle of a cycle
    wb_to_id_valid = 1; wb_reg_waddr = 3; wb_final_result = 32'h55;
    step();
    wb_to_id_valid = 0; rs_addr = 3;
    #2 chk("pre_reset_r3", rs_data, 32'h55);
    resetn = 0;
    #1 chk("async_reset_r3", rs_data, 32'h0);
    step();
    resetn = 1;
    step(); step();

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
